systolic1x4_feeder: RTL and testbench

- Front/back-end controller for the 1x4 systolic MAC array (4 PEs, b cascaded one register per PE).
- Accepts operand beats over valid/ready and drives the array's a0..a3/b0 with matching skew: a_k is delayed k cycles so it meets b at PE k.
- Counts drain cycles after the last beat, captures c0..c3 into a valid/ready result port, then clears the array for the next job.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_skew_line.sv | 29 ++
 rtl/systolic1x4_feeder.sv | 172 +++++++++++++++++
 tb/tb_systolic1x4_feeder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, FSM state type and helpers for the 1x4 systolic feeder.
package systolic_pkg;

    localparam int DATA_W       = 16;
    localparam int ACC_W        = 32;
    localparam int N_PE         = 4;
    localparam int DRAIN_CYCLES = 4;
    localparam int DRAIN_CNT_W  = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// DEPTH-stage shift register with zero reset; delays one operand lane by DEPTH cycles.
module systolic_skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic1x4_feeder.sv
// Feeds skewed operand beats into a 1x4 systolic MAC array, drains it and returns c0..c3
// over valid/ready. Define SYSTOLIC_FEED_PERF_EN to add res_beats/res_cycles job counters.
module systolic1x4_feeder #(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int ACC_W  = systolic_pkg::ACC_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [4*DATA_W-1:0]   i_in_a,
    input  logic [DATA_W-1:0]     i_in_b,
    input  logic                  i_in_last,
    output logic [DATA_W-1:0]     o_arr_a0,
    output logic [DATA_W-1:0]     o_arr_a1,
    output logic [DATA_W-1:0]     o_arr_a2,
    output logic [DATA_W-1:0]     o_arr_a3,
    output logic [DATA_W-1:0]     o_arr_b0,
    output logic                  o_arr_clr,
    input  logic [ACC_W-1:0]      i_arr_c0,
    input  logic [ACC_W-1:0]      i_arr_c1,
    input  logic [ACC_W-1:0]      i_arr_c2,
    input  logic [ACC_W-1:0]      i_arr_c3,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
`ifdef SYSTOLIC_FEED_PERF_EN
    output logic [15:0]           o_res_beats,
    output logic [15:0]           o_res_cycles,
`endif
    output logic [4*ACC_W-1:0]    o_res_c
);

    import systolic_pkg::*;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [DRAIN_CNT_W-1:0]   r_drain_cnt;
    logic                     r_in_ready;
    logic                     r_arr_clr;
    logic                     r_res_valid;
    logic [4*ACC_W-1:0]       r_res_c;
    logic [DATA_W-1:0]        r_arr_b0;
    logic [DATA_W-1:0]        r_arr_a  [N_PE];
    logic [DATA_W-1:0]        w_lane_a [N_PE];
    logic [DATA_W-1:0]        w_skew_a [N_PE];
    logic                     w_accept;
    logic                     w_capture;
    logic                     w_in_ready_next;
    logic                     w_arr_clr_next;
    logic                     w_res_valid_next;

    assign w_accept  = i_in_valid & r_in_ready;
    // PE3 accumulates the last beat on the 4th edge after accept; sample on the 5th.
    assign w_capture = (r_state == DRAIN) && (r_drain_cnt == DRAIN_CNT_W'(DRAIN_CYCLES));

    // Lane k is delayed k cycles so it meets b after b has crossed k PE registers.
    genvar gi;
    generate
        for (gi = 0; gi < N_PE; gi++) begin : g_lane
            assign w_lane_a[gi] = w_accept ? i_in_a[gi*DATA_W +: DATA_W] : '0;
            if (gi == 0) begin : g_direct
                assign w_skew_a[gi] = w_lane_a[gi];
            end else begin : g_skew
                systolic_skew_line #(
                    .DEPTH (gi),
                    .W     (DATA_W)
                ) u_skew (
                    .i_clk   (i_clk),
                    .i_rst_n (i_rst_n),
                    .i_d     (w_lane_a[gi]),
                    .o_q     (w_skew_a[gi])
                );
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_PE; i++) begin
                r_arr_a[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PE; i++) begin
                r_arr_a[i] <= w_skew_a[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= CLEAR;
            r_drain_cnt <= '0;
            r_in_ready  <= 1'b0;
            r_arr_clr   <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_c     <= '0;
            r_arr_b0    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + DRAIN_CNT_W'(1) : '0;
            r_in_ready  <= w_in_ready_next;
            r_arr_clr   <= w_arr_clr_next;
            r_res_valid <= w_res_valid_next;
            r_arr_b0    <= w_accept ? i_in_b : '0;
            if (w_capture) begin
                r_res_c <= {i_arr_c3, i_arr_c2, i_arr_c1, i_arr_c0};
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR:   w_state_next = STREAM;
            STREAM:  if (w_accept && i_in_last) w_state_next = DRAIN;
            DRAIN:   if (w_capture) w_state_next = RESULT;
            RESULT:  if (i_res_ready) w_state_next = CLEAR;
            default: w_state_next = CLEAR;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        w_in_ready_next  = (w_state_next == STREAM);
        w_arr_clr_next   = (w_state_next == CLEAR);
        w_res_valid_next = (w_state_next == RESULT);
    end

`ifdef SYSTOLIC_FEED_PERF_EN
    logic [15:0] r_beat_cnt;
    logic [15:0] r_cyc_cnt;
    logic [15:0] r_res_beats;
    logic [15:0] r_res_cycles;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat_cnt   <= '0;
            r_cyc_cnt    <= '0;
            r_res_beats  <= '0;
            r_res_cycles <= '0;
        end else begin
            if (r_state == CLEAR) begin
                r_beat_cnt <= '0;
                r_cyc_cnt  <= '0;
            end else if (r_state == STREAM || r_state == DRAIN) begin
                r_cyc_cnt <= sat_inc16(r_cyc_cnt);
                if (w_accept) begin
                    r_beat_cnt <= sat_inc16(r_beat_cnt);
                end
            end
            if (w_capture) begin
                r_res_beats  <= r_beat_cnt;
                r_res_cycles <= sat_inc16(r_cyc_cnt);
            end
        end
    end

    assign o_res_beats  = r_res_beats;
    assign o_res_cycles = r_res_cycles;
`endif

    assign o_in_ready  = r_in_ready;
    assign o_arr_clr   = r_arr_clr;
    assign o_res_valid = r_res_valid;
    assign o_res_c     = r_res_c;
    assign o_arr_b0    = r_arr_b0;
    assign o_arr_a0    = r_arr_a[0];
    assign o_arr_a1    = r_arr_a[1];
    assign o_arr_a2    = r_arr_a[2];
    assign o_arr_a3    = r_arr_a[3];

endmodule

// File: tb/tb_systolic1x4_feeder.sv
// Directed bench for systolic1x4_feeder with a behavioural 1x4 MAC array attached.
module tb_systolic1x4_feeder;

    localparam int DW = 16;
    localparam int AW = 32;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_last   = 1'b0;
    logic [4*DW-1:0] in_a      = '0;
    logic [DW-1:0]   in_b      = '0;
    logic            res_ready = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   arr_a0, arr_a1, arr_a2, arr_a3, arr_b0;
    logic            arr_clr;
    logic            res_valid;
    logic [4*AW-1:0] res_c;
    logic [AW-1:0]   arr_c0 = '0, arr_c1 = '0, arr_c2 = '0, arr_c3 = '0;
    logic [DW-1:0]   m_b1 = '0, m_b2 = '0, m_b3 = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic1x4_feeder dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .i_in_last   (in_last),
        .o_arr_a0    (arr_a0),
        .o_arr_a1    (arr_a1),
        .o_arr_a2    (arr_a2),
        .o_arr_a3    (arr_a3),
        .o_arr_b0    (arr_b0),
        .o_arr_clr   (arr_clr),
        .i_arr_c0    (arr_c0),
        .i_arr_c1    (arr_c1),
        .i_arr_c2    (arr_c2),
        .i_arr_c3    (arr_c3),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_c     (res_c)
    );

    // Behavioural array: b cascades one register per PE, each PE accumulates a_k * b_k.
    always @(posedge clk) begin
        if (arr_clr) begin
            m_b1 <= '0; m_b2 <= '0; m_b3 <= '0;
            arr_c0 <= '0; arr_c1 <= '0; arr_c2 <= '0; arr_c3 <= '0;
        end else begin
            m_b1 <= arr_b0; m_b2 <= m_b1; m_b3 <= m_b2;
            arr_c0 <= arr_c0 + AW'(arr_a0) * AW'(arr_b0);
            arr_c1 <= arr_c1 + AW'(arr_a1) * AW'(m_b1);
            arr_c2 <= arr_c2 + AW'(arr_a2) * AW'(m_b2);
            arr_c3 <= arr_c3 + AW'(arr_a3) * AW'(m_b3);
        end
    end

    typedef struct {
        int                n;
        int                gap;
        int                hold;
        logic [3*4*DW-1:0] a;
        logic [3*DW-1:0]   b;
        logic [4*AW-1:0]   c;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input int n, input int gap, input int hold,
                                input logic [3*4*DW-1:0] a, input logic [3*DW-1:0] b,
                                input logic [4*AW-1:0] c);
        vec_t v;
        v.n = n; v.gap = gap; v.hold = hold; v.a = a; v.b = b; v.c = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int budget;
        budget = 0;
        while (!in_ready && budget < 50) begin
            tick;
            budget++;
        end
        check("in_ready_wait", 128'(in_ready), 128'd1);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        for (int i = 0; i < v.n; i++) begin
            wait_ready;
            in_valid = 1'b1;
            in_a     = v.a[i*4*DW +: 4*DW];
            in_b     = v.b[i*DW +: DW];
            in_last  = (i == v.n - 1);
            tick;
            check({tag, "_arr_a0"}, 128'(arr_a0), 128'(v.a[i*4*DW +: DW]));
            check({tag, "_arr_b0"}, 128'(arr_b0), 128'(v.b[i*DW +: DW]));
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i != v.n - 1) begin
                for (int g = 0; g < v.gap; g++) begin
                    tick;
                    check({tag, "_bubble_zero"}, {96'd0, arr_a0, arr_b0}, 128'd0);
                end
            end
        end
        // Result must appear exactly on the 5th edge after the last accept.
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (k < 5) check({tag, "_drain_rv_rdy"}, {126'd0, res_valid, in_ready}, 128'd0);
        end
        check({tag, "_res_valid"}, 128'(res_valid), 128'd1);
        check({tag, "_res_c"}, res_c, v.c);
        for (int h = 0; h < v.hold; h++) begin
            tick;
            check({tag, "_hold_valid"}, 128'(res_valid), 128'd1);
            check({tag, "_hold_c"}, res_c, v.c);
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check({tag, "_post_hs"}, {125'd0, res_valid, arr_clr, in_ready}, {125'd0, 3'b010});
        tick;
        check({tag, "_stream"}, {126'd0, arr_clr, in_ready}, {126'd0, 2'b01});
        $display("job %-8s beats=%0d gap=%0d hold=%0d res_c=%032h", tag, v.n, v.gap, v.hold, res_c);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = mk(1, 0, 0, {128'h0, 64'h0004_0003_0002_0001}, {32'h0, 16'd5},
                     {32'd20, 32'd15, 32'd10, 32'd5});
        vecs[1] = mk(3, 0, 10, {64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001,
                                64'h0004_0003_0002_0001}, {16'd3, 16'd2, 16'd1},
                     {32'd24, 32'd18, 32'd12, 32'd6});
        vecs[2] = mk(3, 2, 0, {64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001,
                               64'h0004_0003_0002_0001}, {16'd3, 16'd2, 16'd1},
                     {32'd24, 32'd18, 32'd12, 32'd6});
        vecs[3] = mk(2, 0, 0, {64'h0, 64'h0003_0002_0001_FFFF, 64'h0003_0002_0001_FFFF},
                     {16'h0, 16'hFFFF, 16'hFFFF},
                     {32'h0005_FFFA, 32'h0003_FFFC, 32'h0001_FFFE, 32'hFFFC_0002});
        vecs[4] = mk(2, 0, 0, {64'h0, 64'h0008_0007_0006_0005, 64'h0004_0003_0002_0001},
                     {16'h0, 16'd10, 16'd1}, {32'd84, 32'd73, 32'd62, 32'd51});
        vecs[5] = mk(1, 0, 0, {128'h0, 64'h0001_0001_0001_0001}, {32'h0, 16'd7},
                     {32'd7, 32'd7, 32'd7, 32'd7});

        // Reset state
        repeat (3) tick;
        check("rst_ctrl", {125'd0, in_ready, res_valid, arr_clr}, {125'd0, 3'b001});
        check("rst_res_c", res_c, 128'd0);
        check("rst_lanes", {48'd0, arr_a3, arr_a2, arr_a1, arr_a0, arr_b0}, 128'd0);
        rst_n = 1'b1;
        check("clear_cycle", 128'(arr_clr), 128'd1);
        tick;
        check("first_stream", {126'd0, arr_clr, in_ready}, {126'd0, 2'b01});

        for (int j = 0; j < 5; j++) begin
            run_job(vecs[j], $sformatf("vec%0d", j));
        end

        // Abort a job mid-drain with an asynchronous reset pulse
        wait_ready;
        in_valid = 1'b1;
        in_a     = 64'h0009_0009_0009_0009;
        in_b     = 16'd9;
        in_last  = 1'b1;
        tick;
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick;
        tick;
        check("mid_drain_rdy", 128'(in_ready), 128'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {125'd0, res_valid, arr_clr, in_ready}, {125'd0, 3'b010});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("job abort    reset pulsed during drain");
        run_job(vecs[5], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
